// File: rtl/x_bus_arbiter.sv
// rtl/x_bus_arbiter.sv - four-lane round-robin owner of the shared x resource.
// Define X_ARB_FIXED_PRIO_EN for fixed priority (lane 0 highest, no RR pointer).
module x_bus_arbiter #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [15:0] data_in,
   output logic [3:0]  gnt,
   output logic [3:0]  x,
   output logic        x_valid,
   output logic        done,
   output logic [1:0]  done_id,
   output logic        busy
);

   // HOLD_CYCLES of 0 is treated as 1, so both load a zero count.
   localparam logic [2:0] HOLD_LOAD = (HOLD_CYCLES <= 1) ? 3'd0 : 3'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  gnt_q, gnt_d;
   logic [3:0]  x_q, x_d;
   logic        x_valid_q, x_valid_d;
   logic        done_q, done_d;
   logic [1:0]  done_id_q, done_id_d;
   logic        busy_q, busy_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [1:0]  owner_q, owner_d;
   logic [1:0]  win_idx;

`ifdef X_ARB_FIXED_PRIO_EN
   always_comb begin
      win_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (req[i]) win_idx = 2'(i);
      end
   end
`else
   logic [1:0]  ptr_q, ptr_d;
   logic [1:0]  cand;
   logic        found;

   // Search starts just after the last winner, so the previous owner is checked last.
   always_comb begin
      win_idx = ptr_q;
      found   = 1'b0;
      cand    = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         cand = ptr_q + 2'(i);
         if (!found && req[cand]) begin
            win_idx = cand;
            found   = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      x_d       = x_q;
      x_valid_d = x_valid_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      owner_d   = owner_q;
`ifndef X_ARB_FIXED_PRIO_EN
      ptr_d     = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d   = GRANT;
               gnt_d     = 4'b0001 << win_idx;
               x_d       = data_in[{win_idx, 2'b00} +: 4];
               x_valid_d = 1'b1;
               busy_d    = 1'b1;
               cnt_d     = HOLD_LOAD;
               owner_d   = win_idx;
`ifndef X_ARB_FIXED_PRIO_EN
               ptr_d     = win_idx;
`endif
            end
         end
         GRANT: begin
            // Expiry and a dropped request on the same edge collapse into one release.
            if (cnt_q == 3'd0 || !req[owner_q]) begin
               state_d   = RELEASE;
               gnt_d     = 4'b0000;
               x_valid_d = 1'b0;
               done_d    = 1'b1;
               done_id_d = owner_q;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RELEASE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d   = IDLE;
            gnt_d     = 4'b0000;
            x_valid_d = 1'b0;
            busy_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= 4'b0000;
         x_q       <= 4'h0;
         x_valid_q <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 2'd0;
         busy_q    <= 1'b0;
         cnt_q     <= 3'd0;
         owner_q   <= 2'd0;
`ifndef X_ARB_FIXED_PRIO_EN
         ptr_q     <= 2'd3;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         owner_q   <= owner_d;
`ifndef X_ARB_FIXED_PRIO_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   assign gnt     = gnt_q;
   assign x       = x_q;
   assign x_valid = x_valid_q;
   assign done    = done_q;
   assign done_id = done_id_q;
   assign busy    = busy_q;

endmodule

// File: doc/x_bus_arbiter.md
# x_bus_arbiter

Round-robin arbiter that shares the single 4-bit `x` output resource of the `Experimental` datapath among four requesters. It grants the resource to one requester at a time and latches that requester's 4-bit value onto `x`. It holds the grant for a bounded number of cycles, then releases and re-arbitrates. It sits between the requester logic and the `x` consumer and is the only block that drives `x`.

## Interface
- `HOLD_CYCLES`, 4, grant duration in cycles; legal range 1..7; 0 behaves as 1.
- `clk`  input  1  single system clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `req`  input  4  request per lane; bit i = requester i.
- `data_in`  input  16  lane data; lane i = `data_in[4*i+3:4*i]`.
- `gnt`  output  4  one-hot grant; all-zero when no owner.
- `x`  output  4  shared resource value driven to the consumer.
- `x_valid`  output  1  high while `x` carries a granted value.
- `done`  output  1  one-cycle pulse when a grant ends.
- `done_id`  output  2  lane index of the grant that just ended; valid with `done`.
- `busy`  output  1  high in GRANT and RELEASE.

## Operation
- Reset values: state IDLE, `gnt`=0, `x`=0, `x_valid`=0, `done`=0, `done_id`=0, `busy`=0, hold counter 0, RR pointer 3, so lane 0 wins first.
- States:
  - IDLE: no owner.
  - GRANT: lane owns `x`.
  - RELEASE: one cycle, gnt=0, `done`=1.
- IDLE -> GRANT when `req`≠0.
  - Winner: first set bit searching from pointer+1 upward, modulo 4.
  - At that edge: `gnt`<=onehot(winner), `x`<=winner's lane data, `x_valid`<=1, counter<=HOLD_CYCLES-1, pointer<=winner.
- GRANT: `x` is captured once at grant; lane data changes during GRANT are ignored.
  - GRANT -> RELEASE when counter==0 or owner's `req` bit is 0; otherwise counter decrements.
- RELEASE: `gnt`=0, `x_valid`=0, `busy`=1, `done`=1, `done_id`=owner index.
  - `x` keeps its last value.
  - RELEASE -> IDLE unconditionally.
- Requests from non-owners during GRANT/RELEASE are not lost; they are sampled again in IDLE.
- Owner re-requesting after release competes normally; round-robin gives other pending lanes priority.
- `req` changes in IDLE take effect on the next sampled edge. There is no request latching: a request dropped before being sampled is not served.

## Timing
- Cycle 0: `req` sampled high in IDLE. Cycle 1: `gnt`/`x`/`x_valid` valid.
- Full grant: `gnt` high exactly HOLD_CYCLES cycles, then 1 RELEASE cycle, then 1 IDLE cycle.
  - Max throughput: one grant per HOLD_CYCLES+2 cycles.
- Early release: owner `req` sampled low at GRANT edge k gives RELEASE at k+1.
  - Minimum grant is 1 cycle; a drop and the counter expiring on the same edge give one RELEASE, not two.
- `gnt` and `x_valid` are never high in RELEASE or IDLE; `gnt` never has more than one bit set.
- `rst_n` low at any time, including mid-GRANT: all outputs go to reset values immediately (asynchronous). No `done` is issued for the aborted grant. The first grant after reset goes to the lowest requesting lane ≥0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `X_ARB_FIXED_PRIO_EN` defined:
  - Priority is fixed, with lane 0 highest and lane 3 lowest.
  - The RR pointer is not implemented; `done`/`done_id` behaviour is unchanged.
- Undefined (default): round-robin as described.

## Test plan
- Reset: `rst_n`=0 with `req`=4'b1111 -> all outputs 0. Release reset -> lane 0 granted one cycle after the first sampled edge, `x`=lane 0 data.
- Single lane: `req`=4'b0100, lane 2 data 4'hA, HOLD_CYCLES=4 -> `gnt`=4'b0100 and `x`=4'hA for 4 cycles. Then `done`=1 with `done_id`=2, then IDLE.
- Rotation: `req`=4'b1111 held -> grant order 0,1,2,3,0, each spaced HOLD_CYCLES+2 cycles.
  - With `X_ARB_FIXED_PRIO_EN`: lane 0 every time.
- Early release: lane 1 granted, `req[1]` dropped after 2 grant cycles -> RELEASE next cycle, `done_id`=1. Lane 1 data changed mid-grant -> `x` unchanged.
- Mid-grant reset: assert `rst_n`=0 during GRANT -> `gnt`, `x`, `x_valid` clear the same cycle with no `done`. Re-arbitration after reset restarts from lane 0.
- HOLD_CYCLES=1 and 0: each grant is exactly 1 cycle, followed by one `done` pulse.
